// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 constants: instruction codes, register IDs,
//               status codes and the E-stage pipeline register layout with
//               its bubble (nop) value.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package y86_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Register identifiers
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

   // Status codes
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   // Defaults for the register file
   localparam int          NREG_DEF     = 15;
   localparam logic [63:0] RSP_INIT_DEF = 64'h200;

   // Contents of the E pipeline register
   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] valA;
      logic [63:0] valB;
      logic [63:0] valC;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
      logic [3:0]  srcA;
      logic [3:0]  srcB;
   } e_reg_t;

   // Bubble: a nop with AOK status that touches no register
   localparam e_reg_t E_BUBBLE = '{
      stat  : SAOK,
      icode : INOP,
      ifun  : 4'h0,
      valA  : 64'h0,
      valB  : 64'h0,
      valC  : 64'h0,
      dstE  : RNONE,
      dstM  : RNONE,
      srcA  : RNONE,
      srcB  : RNONE
   };

endpackage

`default_nettype wire

// File: rtl/y86_regfile.sv
// ============================================================================
// Module      : y86_regfile
// Description : Y86-64 architectural register file, NREG x 64 bits.
//               Two asynchronous read ports, two synchronous write ports
//               (E and M) with M taking priority when both target the same
//               register. Synchronous active-high reset loads 0 everywhere
//               except %rsp, which loads RSP_INIT.
// Ports       : clk, rst           clock, synchronous reset
//               rd_a_i / rd_a_o    read port A address / data
//               rd_b_i / rd_b_o    read port B address / data
//               wr_e_addr_i/data_i write port E (ignored when address is F)
//               wr_m_addr_i/data_i write port M (ignored when address is F)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module y86_regfile
   import y86_pkg::*;
#(
   parameter int          NREG     = NREG_DEF,
   parameter logic [63:0] RSP_INIT = RSP_INIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  rd_a_i,
   output logic [63:0] rd_a_o,
   input  logic [3:0]  rd_b_i,
   output logic [63:0] rd_b_o,
   input  logic [3:0]  wr_e_addr_i,
   input  logic [63:0] wr_e_data_i,
   input  logic [3:0]  wr_m_addr_i,
   input  logic [63:0] wr_m_data_i
);

   logic [63:0] rf_q [NREG];

   // Each register resolves its own write; checking M before E gives the
   // popq %rsp case its loaded value. RNONE never matches a real index.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rst) begin
            rf_q[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'h0;
         end else if (wr_m_addr_i != RNONE && wr_m_addr_i == 4'(i)) begin
            rf_q[i] <= wr_m_data_i;
         end else if (wr_e_addr_i != RNONE && wr_e_addr_i == 4'(i)) begin
            rf_q[i] <= wr_e_data_i;
         end
      end
   end

   // RNONE reads as zero so the array is never indexed past its end
   assign rd_a_o = (rd_a_i != RNONE) ? rf_q[rd_a_i] : 64'h0;
   assign rd_b_o = (rd_b_i != RNONE) ? rf_q[rd_b_i] : 64'h0;

endmodule

`default_nettype wire

// File: rtl/decode_regread.sv
// ============================================================================
// Module      : decode_regread
// Description : Y86-64 decode stage. Decodes source/destination registers
//               from the D register, reads the register file with
//               forwarding from E, M and W, and loads the E pipeline
//               register. Owns the register file, written by the W stage.
// Ports       : clk, rst                     clock, synchronous reset
//               D_*                          fetch-stage pipeline register
//               E_bubble                     load a nop into E
//               e_dstE/e_valE                execute forwarding
//               M_dstE/M_dstM/M_valE/m_valM  memory forwarding
//               W_dstE/W_dstM/W_valE/W_valM  writeback forwarding + write port
//               d_srcA, d_srcB               decoded sources (hazard unit)
//               E_*                          execute-stage pipeline register
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_regread
   import y86_pkg::*;
#(
   parameter int          NREG     = NREG_DEF,
   parameter logic [63:0] RSP_INIT = RSP_INIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  D_stat,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_ifun,
   input  logic [3:0]  D_rA,
   input  logic [3:0]  D_rB,
   input  logic [63:0] D_valC,
   input  logic [63:0] D_valP,
   input  logic        E_bubble,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  W_dstE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valE,
   input  logic [63:0] W_valM,
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   output logic [2:0]  E_stat,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   output logic [63:0] E_valC,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB
);

   logic [3:0]  dec_srcA, dec_srcB, dec_dstE, dec_dstM;
   logic [63:0] rf_a, rf_b;
   logic [63:0] fwd_valA, fwd_valB;
   e_reg_t      e_d, e_q;

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   y86_regfile #(
      .NREG     (NREG),
      .RSP_INIT (RSP_INIT)
   ) u_regfile (
      .clk         (clk),
      .rst         (rst),
      .rd_a_i      (dec_srcA),
      .rd_a_o      (rf_a),
      .rd_b_i      (dec_srcB),
      .rd_b_o      (rf_b),
      .wr_e_addr_i (W_dstE),
      .wr_e_data_i (W_valE),
      .wr_m_addr_i (W_dstM),
      .wr_m_data_i (W_valM)
   );

   // ------------------------------------------------------------------
   // Register decode. cmov (rrmovq family) always names rB as dstE;
   // execute suppresses the write when the condition fails.
   // ------------------------------------------------------------------
   always_comb begin
      dec_srcA = RNONE;
      dec_srcB = RNONE;
      dec_dstE = RNONE;
      dec_dstM = RNONE;
      case (D_icode)
         IRRMOVQ: begin dec_srcA = D_rA; dec_dstE = D_rB; end
         IIRMOVQ: begin dec_dstE = D_rB; end
         IRMMOVQ: begin dec_srcA = D_rA; dec_srcB = D_rB; end
         IMRMOVQ: begin dec_srcB = D_rB; dec_dstM = D_rA; end
         IOPQ:    begin dec_srcA = D_rA; dec_srcB = D_rB; dec_dstE = D_rB; end
         ICALL:   begin dec_srcB = RRSP; dec_dstE = RRSP; end
         IRET:    begin dec_srcA = RRSP; dec_srcB = RRSP; dec_dstE = RRSP; end
         IPUSHQ:  begin dec_srcA = D_rA; dec_srcB = RRSP; dec_dstE = RRSP; end
         IPOPQ:   begin
            dec_srcA = RRSP; dec_srcB = RRSP; dec_dstE = RRSP; dec_dstM = D_rA;
         end
         default: ;
      endcase
   end

   assign d_srcA = dec_srcA;
   assign d_srcB = dec_srcB;

   // ------------------------------------------------------------------
   // Operand selection. Youngest producer wins; within M and W the loaded
   // value (dstM) is checked before dstE so popq %rsp forwards the pop.
   // The RNONE term comes first so an idle stage (dst=F) never matches.
   // ------------------------------------------------------------------
   always_comb begin
      fwd_valA = rf_a;
      if (D_icode == ICALL || D_icode == IJXX) fwd_valA = D_valP;
      else if (dec_srcA == RNONE)              fwd_valA = 64'h0;
      else if (dec_srcA == e_dstE)             fwd_valA = e_valE;
      else if (dec_srcA == M_dstM)             fwd_valA = m_valM;
      else if (dec_srcA == M_dstE)             fwd_valA = M_valE;
      else if (dec_srcA == W_dstM)             fwd_valA = W_valM;
      else if (dec_srcA == W_dstE)             fwd_valA = W_valE;
   end

   always_comb begin
      fwd_valB = rf_b;
      if (dec_srcB == RNONE)       fwd_valB = 64'h0;
      else if (dec_srcB == e_dstE) fwd_valB = e_valE;
      else if (dec_srcB == M_dstM) fwd_valB = m_valM;
      else if (dec_srcB == M_dstE) fwd_valB = M_valE;
      else if (dec_srcB == W_dstM) fwd_valB = W_valM;
      else if (dec_srcB == W_dstE) fwd_valB = W_valE;
   end

   // ------------------------------------------------------------------
   // E pipeline register
   // ------------------------------------------------------------------
   always_comb begin
      e_d       = E_BUBBLE;
      e_d.stat  = D_stat;
      e_d.icode = D_icode;
      e_d.ifun  = D_ifun;
      e_d.valA  = fwd_valA;
      e_d.valB  = fwd_valB;
      e_d.valC  = D_valC;
      e_d.dstE  = dec_dstE;
      e_d.dstM  = dec_dstM;
      e_d.srcA  = dec_srcA;
      e_d.srcB  = dec_srcB;
   end

   always_ff @(posedge clk) begin
      if (rst || E_bubble) e_q <= E_BUBBLE;
      else                 e_q <= e_d;
   end

   assign E_stat  = e_q.stat;
   assign E_icode = e_q.icode;
   assign E_ifun  = e_q.ifun;
   assign E_valA  = e_q.valA;
   assign E_valB  = e_q.valB;
   assign E_valC  = e_q.valC;
   assign E_dstE  = e_q.dstE;
   assign E_dstM  = e_q.dstM;
   assign E_srcA  = e_q.srcA;
   assign E_srcB  = e_q.srcB;

endmodule

`default_nettype wire

// File: tb/tb_decode_regread.sv
// ============================================================================
// Module      : tb_decode_regread
// Description : Self-checking bench for decode_regread: directed scenarios
//               followed by random traffic, all compared against a
//               behavioural register-file/forwarding model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_regread;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  D_stat;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic        E_bubble;
   logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic [3:0]  d_srcA, d_srcB;
   logic [2:0]  E_stat;
   logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valA, E_valB, E_valC;

   int total = 0;
   int bad   = 0;

   logic [63:0] rf_m [15];

   always #5 clk = ~clk;

   decode_regread dut (
      .clk(clk), .rst(rst),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
      .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
      .E_bubble(E_bubble),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
      .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB})             return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6})       return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h2, 4'h3, 4'h6})       return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   // Producers listed from youngest to oldest; first hit supplies the value
   function automatic logic [63:0] m_read(input logic [3:0] s);
      logic [3:0]  d [5];
      logic [63:0] v [5];
      if (s == 4'hF) return 64'h0;
      d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
      v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
      for (int k = 0; k < 5; k++)
         if (d[k] == s) return v[k];
      return rf_m[s];
   endfunction

   task automatic idle();
      rst = 1'b0; E_bubble = 1'b0;
      D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0;
      D_rA = 4'hF; D_rB = 4'hF; D_valC = 64'h0; D_valP = 64'h0;
      e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
      e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_valE = 64'h0; W_valM = 64'h0;
   endtask

   // Check decode, clock one edge, check E, then advance the model
   task automatic step();
      logic [3:0]  xsA, xsB, xdE, xdM;
      logic [63:0] xvA, xvB;
      logic        xbub;
      #1;
      xsA = m_srcA(D_icode, D_rA);
      xsB = m_srcB(D_icode, D_rB);
      xdE = m_dstE(D_icode, D_rB);
      xdM = m_dstM(D_icode, D_rA);
      xvA = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_read(xsA);
      xvB = m_read(xsB);
      xbub = rst || E_bubble;
      chk("d_srcA", {60'h0, d_srcA}, {60'h0, xsA});
      chk("d_srcB", {60'h0, d_srcB}, {60'h0, xsB});
      @(posedge clk);
      #1;
      chk("E_stat",  {61'h0, E_stat},  xbub ? 64'd1 : {61'h0, D_stat});
      chk("E_icode", {60'h0, E_icode}, xbub ? 64'd1 : {60'h0, D_icode});
      chk("E_ifun",  {60'h0, E_ifun},  xbub ? 64'd0 : {60'h0, D_ifun});
      chk("E_valA",  E_valA,           xbub ? 64'd0 : xvA);
      chk("E_valB",  E_valB,           xbub ? 64'd0 : xvB);
      chk("E_valC",  E_valC,           xbub ? 64'd0 : D_valC);
      chk("E_dstE",  {60'h0, E_dstE},  xbub ? 64'hF : {60'h0, xdE});
      chk("E_dstM",  {60'h0, E_dstM},  xbub ? 64'hF : {60'h0, xdM});
      chk("E_srcA",  {60'h0, E_srcA},  xbub ? 64'hF : {60'h0, xsA});
      chk("E_srcB",  {60'h0, E_srcB},  xbub ? 64'hF : {60'h0, xsB});
      if (rst) begin
         for (int k = 0; k < 15; k++) rf_m[k] = (k == 4) ? 64'h200 : 64'h0;
      end else begin
         if (W_dstE != 4'hF) rf_m[W_dstE] = W_valE;
         if (W_dstM != 4'hF) rf_m[W_dstM] = W_valM;
      end
   endtask

   function automatic logic [3:0] pick();
      int r;
      r = $urandom_range(0, 19);
      return (r >= 16) ? 4'h4 : 4'(r);
   endfunction

   initial begin
      for (int k = 0; k < 15; k++) rf_m[k] = 64'h0;
      idle();

      // Reset, then read %rsp with nothing in flight
      rst = 1'b1; D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
      step();
      chk("rst_icode", {60'h0, E_icode}, 64'd1);
      chk("rst_dstE",  {60'h0, E_dstE},  64'hF);
      chk("rst_stat",  {61'h0, E_stat},  64'd1);
      idle(); D_icode = 4'h9;
      step();
      chk("rsp_init", E_valA, 64'h200);

      // Write r3 then rrmovq r3 -> r6
      idle(); W_dstE = 4'h3; W_valE = 64'h55;
      step();
      idle(); D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h6;
      step();
      chk("wr_rd_valA", E_valA, 64'h55);
      chk("wr_rd_dstE", {60'h0, E_dstE}, 64'h6);

      // Forwarding priority e > M > W
      idle(); D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h7;
      e_dstE = 4'h2; e_valE = 64'd1;
      M_dstE = 4'h2; M_valE = 64'd2;
      W_dstE = 4'h2; W_valE = 64'd3;
      step();
      chk("prio_e", E_valA, 64'd1);
      e_dstE = 4'hF;
      step();
      chk("prio_M", E_valA, 64'd2);
      M_dstE = 4'hF;
      step();
      chk("prio_W", E_valA, 64'd3);

      // popq %rsp: loaded value wins, both forwarded and stored
      idle(); W_dstE = 4'h4; W_valE = 64'd8; W_dstM = 4'h4; W_valM = 64'd9;
      D_icode = 4'h9;
      step();
      chk("popq_fwd", E_valA, 64'd9);
      idle(); D_icode = 4'h9;
      step();
      chk("popq_rf", E_valA, 64'd9);

      // call
      idle(); D_icode = 4'h8; D_valP = 64'h1234;
      step();
      chk("call_valA", E_valA, 64'h1234);
      chk("call_srcB", {60'h0, d_srcB}, 64'h4);
      chk("call_dstE", {60'h0, E_dstE}, 64'h4);

      // Bubble over a valid mrmovq, then mid-stream reset beating a W write
      idle(); D_icode = 4'h5; D_rA = 4'h1; D_rB = 4'h2; D_valC = 64'h99;
      E_bubble = 1'b1;
      step();
      chk("bub_icode", {60'h0, E_icode}, 64'd1);
      chk("bub_dstM",  {60'h0, E_dstM},  64'hF);
      E_bubble = 1'b0;
      step();
      chk("mrm_icode", {60'h0, E_icode}, 64'h5);
      idle(); rst = 1'b1; W_dstE = 4'h3; W_valE = 64'h77;
      D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h4;
      step();
      chk("mid_rst_icode", {60'h0, E_icode}, 64'd1);
      idle(); D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h4;
      step();
      chk("mid_rst_r3",  E_valA, 64'h0);
      chk("mid_rst_rsp", E_valB, 64'h200);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 49) == 0);
         E_bubble = ($urandom_range(0, 9) == 0);
         D_stat   = 3'($urandom_range(1, 4));
         D_icode  = 4'($urandom_range(0, 15));
         D_ifun   = 4'($urandom_range(0, 15));
         D_rA = pick(); D_rB = pick();
         D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
         e_dstE = pick(); M_dstE = pick(); M_dstM = pick();
         W_dstE = pick(); W_dstM = pick();
         e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
         m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
         W_valM = {$urandom, $urandom};
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
